// File: rtl/acqbuf_writer_if.sv
// Acquisition-buffer BRAM write port.
//   master: addr_acqbuf, data_acqbuf, we_acqbuf driven by the writer.
//   slave : the same signals as inputs, used by the BRAM or by an observer.
interface acqbuf_writer_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 12
) ();
  logic [ADDRWIDTH-1:0] addr_acqbuf;
  logic [DATAWIDTH-1:0] data_acqbuf;
  logic                 we_acqbuf;

  modport master (output addr_acqbuf, output data_acqbuf, output we_acqbuf);
  modport slave  (input  addr_acqbuf, input  data_acqbuf, input  we_acqbuf);
endinterface

// File: rtl/acqbuf_writer.sv
// Captures one selected sample stream into the acquisition buffer after a
// start strobe. The capture waits a programmable number of cycles, then writes
// one sample in every (decimator+1) cycles until all 2^ADDRWIDTH locations are
// filled.
// Ports:
//   clk, reset (async, active low)
//   src            : NCHAN packed sample streams
//   chansel, delayaftertrig, decimator : configuration, latched on accepted start
//   stb_start      : start strobe, honoured in IDLE only
//   acqbufreset    : synchronous abort/rearm, highest priority
//   wr (master)    : BRAM write port (addr_acqbuf, data_acqbuf, we_acqbuf)
//   busy, done     : status
module acqbuf_writer #(
  parameter int NCHAN     = 4,
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCHAN*DATAWIDTH-1:0] src,
  input  logic [15:0]                chansel,
  input  logic                       stb_start,
  input  logic [31:0]                delayaftertrig,
  input  logic [15:0]                decimator,
  input  logic                       acqbufreset,
  acqbuf_writer_if.master            wr,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_CAPTURE, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            chsel_q, chsel_d;
  logic [31:0]            delay_q, delay_d;
  logic [15:0]            dec_q, dec_d;
  logic [31:0]            dcnt_q, dcnt_d;
  logic [15:0]            deccnt_q, deccnt_d;
  logic [ADDRWIDTH-1:0]   widx_q, widx_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [DATAWIDTH-1:0]   data_q, data_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [DATAWIDTH-1:0]   sample;

  // Out-of-range channel indices fall through to zero data.
  always_comb begin
    sample = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (chsel_q == 16'(i)) sample = src[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    chsel_d  = chsel_q;
    delay_d  = delay_q;
    dec_d    = dec_q;
    dcnt_d   = dcnt_q;
    deccnt_d = deccnt_q;
    widx_d   = widx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;

    if (acqbufreset) begin
      state_d = S_IDLE;
      widx_d  = '0;
      addr_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stb_start) begin
            chsel_d  = chansel;
            delay_d  = delayaftertrig;
            dec_d    = decimator;
            dcnt_d   = '0;
            deccnt_d = '0;
            state_d  = (delayaftertrig != '0) ? S_DELAY : S_CAPTURE;
          end
        end
        S_DELAY: begin
          // Compare against D-1 so that exactly D cycles are spent here.
          if (dcnt_q == delay_q - 32'd1) state_d = S_CAPTURE;
          else                           dcnt_d  = dcnt_q + 32'd1;
        end
        S_CAPTURE: begin
          deccnt_d = (deccnt_q == dec_q) ? '0 : deccnt_q + 16'd1;
          if (deccnt_q == '0) begin
            we_d   = 1'b1;
            addr_d = widx_q;
            data_d = sample;
            widx_d = widx_q + 1'b1;
            if (widx_q == '1) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_DELAY) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      chsel_q  <= '0;
      delay_q  <= '0;
      dec_q    <= '0;
      dcnt_q   <= '0;
      deccnt_q <= '0;
      widx_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      chsel_q  <= chsel_d;
      delay_q  <= delay_d;
      dec_q    <= dec_d;
      dcnt_q   <= dcnt_d;
      deccnt_q <= deccnt_d;
      widx_q   <= widx_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign wr.addr_acqbuf = addr_q;
  assign wr.data_acqbuf = data_q;
  assign wr.we_acqbuf   = we_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_acqbuf_writer.sv
module tb_acqbuf_writer;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int N   = 16;

  logic              clk = 1'b0;
  logic              clk_en = 1'b1;
  logic              rst_n = 1'b0;
  logic [NCH*DW-1:0] src = '0;
  logic [15:0]       chansel = '0;
  logic              stb_start = 1'b0;
  logic [31:0]       delayaftertrig = '0;
  logic [15:0]       decimator = '0;
  logic              acqbufreset = 1'b0;
  logic              busy, done;

  acqbuf_writer_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) wr_if ();

  acqbuf_writer #(.NCHAN(NCH), .DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .src           (src),
    .chansel       (chansel),
    .stb_start     (stb_start),
    .delayaftertrig(delayaftertrig),
    .decimator     (decimator),
    .acqbufreset   (acqbufreset),
    .wr            (wr_if),
    .busy          (busy),
    .done          (done)
  );

  // Clock halts in the low phase when clk_en drops.
  always #5 if (clk_en || clk) clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a capture is a start edge k plus its configuration;
  // write j lands on edge k+1+D+j*(dec+1), the last one ending the capture.
  longint        e, m_k, m_D, m_dec, m_t, m_j;
  int            m_ch;
  bit            m_act, m_done;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_data, m_samp;
  logic          x_we, x_busy, x_done;

  assign m_t = e - (m_k + 1 + m_D);
  assign m_j = m_t / (m_dec + 1);
  always_comb m_samp = (m_ch < NCH) ? src[m_ch*DW +: DW] : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= 0; m_k <= 0; m_D <= 0; m_dec <= 0; m_ch <= 0;
      m_act <= 0; m_done <= 0;
      x_addr <= '0; x_data <= '0; x_we <= 0; x_busy <= 0; x_done <= 0;
    end else begin
      e    <= e + 1;
      x_we <= 0;
      if (acqbufreset) begin
        m_act <= 0; m_done <= 0;
        x_addr <= '0; x_busy <= 0; x_done <= 0;
      end else if (m_act) begin
        if (m_t >= 0 && (m_t % (m_dec + 1)) == 0) begin
          x_we   <= 1;
          x_addr <= m_j[AW-1:0];
          x_data <= m_samp;
          if (m_j == N - 1) begin
            m_act <= 0; m_done <= 1; x_busy <= 0; x_done <= 1;
          end
        end
      end else if (!m_done && stb_start) begin
        m_act  <= 1;
        m_k    <= e;
        m_D    <= longint'(delayaftertrig);
        m_dec  <= longint'(decimator);
        m_ch   <= int'(chansel);
        x_busy <= 1;
      end
    end
  end

  int nwrites = 0;
  int nnonzero = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("we",   64'(wr_if.we_acqbuf),   64'(x_we));
      chk("addr", 64'(wr_if.addr_acqbuf), 64'(x_addr));
      chk("data", 64'(wr_if.data_acqbuf), 64'(x_data));
      chk("busy", 64'(busy),              64'(x_busy));
      chk("done", 64'(done),              64'(x_done));
      if (wr_if.we_acqbuf) begin
        nwrites++;
        if (wr_if.data_acqbuf != '0) nnonzero++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    src = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Pulses a start, then scrambles the configuration inputs so that any
  // use of unlatched values shows up as a data or timing error.
  task automatic start(int ch, int d, int dc);
    chansel = 16'(ch); delayaftertrig = 32'(d); decimator = 16'(dc);
    stb_start = 1'b1;
    tick();
    stb_start = 1'b0;
    chansel = 16'($urandom); delayaftertrig = $urandom; decimator = 16'($urandom);
  endtask

  task automatic wait_done(int maxc, output int n);
    n = 0;
    while (!done && n < maxc) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic rearm();
    acqbufreset = 1'b1;
    tick();
    acqbufreset = 1'b0;
  endtask

  initial begin
    int n;
    int guard;
    #1;
    chk("rst_addr", 64'(wr_if.addr_acqbuf), 64'd0);
    chk("rst_data", 64'(wr_if.data_acqbuf), 64'd0);
    chk("rst_we",   64'(wr_if.we_acqbuf),   64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic capture.
    nwrites = 0;
    start(2, 0, 0);
    wait_done(100, n);
    chk("basic_latency", 64'(n), 64'd16);
    tick();
    chk("basic_we_fall", 64'(wr_if.we_acqbuf), 64'd0);
    chk("basic_writes", 64'(nwrites), 64'd16);

    // Strobe while DONE is ignored.
    start(1, 0, 0);
    repeat (5) tick();
    chk("done_hold", 64'(done), 64'd1);
    chk("done_nowrite", 64'(nwrites), 64'd16);
    rearm();
    chk("rearm_done", 64'(done), 64'd0);

    // Delay and decimation.
    nwrites = 0;
    start(1, 5, 2);
    wait_done(200, n);
    chk("dly_dec_latency", 64'(n), 64'd51);
    tick();
    chk("dly_dec_writes", 64'(nwrites), 64'd16);
    rearm();

    // Strobe and channel change mid-capture.
    start(3, 2, 1);
    repeat (10) tick();
    chansel = 16'd0; stb_start = 1'b1;
    tick();
    stb_start = 1'b0;
    wait_done(200, n);
    chk("midstrobe_latency", 64'(n + 11), 64'd33);
    rearm();

    // Abort at address 7 with a simultaneous start.
    start(0, 0, 1);
    guard = 0;
    while (!(wr_if.we_acqbuf && wr_if.addr_acqbuf == 4'd7) && guard < 100) begin
      tick();
      guard++;
    end
    chk("abort_reach7", 64'(wr_if.addr_acqbuf), 64'd7);
    acqbufreset = 1'b1; stb_start = 1'b1;
    tick();
    acqbufreset = 1'b0; stb_start = 1'b0;
    chk("abort_we",   64'(wr_if.we_acqbuf),   64'd0);
    chk("abort_busy", 64'(busy),              64'd0);
    chk("abort_addr", 64'(wr_if.addr_acqbuf), 64'd0);
    repeat (2) tick();
    chk("abort_start_ignored", 64'(busy), 64'd0);
    start(2, 0, 0);
    tick();
    chk("restart_we",   64'(wr_if.we_acqbuf),   64'd1);
    chk("restart_addr", 64'(wr_if.addr_acqbuf), 64'd0);
    wait_done(100, n);
    rearm();

    // Invalid channel.
    nwrites = 0; nnonzero = 0;
    start(NCH, 0, 0);
    wait_done(100, n);
    tick();
    chk("badch_writes", 64'(nwrites), 64'd16);
    chk("badch_zero",   64'(nnonzero), 64'd0);
    rearm();

    // Random configurations with stray strobes and occasional aborts.
    for (int it = 0; it < 12; it++) begin
      start($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 3));
      for (int c = 0; c < 90; c++) begin
        stb_start   = ($urandom_range(0, 9) == 0);
        acqbufreset = ($urandom_range(0, 149) == 0);
        chansel = 16'($urandom_range(0, 5));
        delayaftertrig = 32'($urandom_range(0, 7));
        decimator = 16'($urandom_range(0, 3));
        tick();
      end
      stb_start = 1'b0;
      rearm();
    end

    // Asynchronous reset with the clock stopped mid-delay.
    start(1, 20, 0);
    repeat (3) tick();
    chk("async_busy_before", 64'(busy), 64'd1);
    clk_en = 1'b0;
    #20;
    rst_n = 1'b0;
    #1;
    chk("async_addr", 64'(wr_if.addr_acqbuf), 64'd0);
    chk("async_data", 64'(wr_if.data_acqbuf), 64'd0);
    chk("async_we",   64'(wr_if.we_acqbuf),   64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    #20;
    rst_n = 1'b1;
    #7;
    clk_en = 1'b1;
    tick();
    nwrites = 0;
    start(2, 0, 0);
    wait_done(100, n);
    chk("post_async_latency", 64'(n), 64'd16);
    tick();
    chk("post_async_writes", 64'(nwrites), 64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
